// File: rtl/adc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adc_pkg
//  Description : Shared types and helpers for the parallel-ADC sampler:
//                FSM state enum, sample word type, counter sizing helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package adc_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CONV     = 3'd1,
    S_WAIT_EOC = 3'd2,
    S_READ     = 3'd3,
    S_GAP      = 3'd4
  } adc_state_t;

  // Largest of three cycle counts; sizes the shared phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage : adc_pkg
`default_nettype wire

// File: rtl/sync_fall.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fall
//  Description : Two-flop synchronizer for an asynchronous active-low strobe
//                followed by a falling-edge detector (one-cycle pulse).
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fall (
  input  logic clk,
  input  logic rst,
  input  logic i_async_n,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchronize the strobe and keep one cycle of history; idle level is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_async_n;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_fall = r_prev & ~r_sync;

endmodule : sync_fall
`default_nettype wire

// File: rtl/adc_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : adc_sampler
//  Description : Periodic conversion controller for a parallel-output ADC.
//                Issues CONVST, waits for EOC (with timeout), reads DB with
//                CS/RD, and hands samples downstream via valid/ready with
//                overrun detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_sampler
  import adc_pkg::*;
#(
  parameter int PERIOD     = 1000,
  parameter int CONVST_LOW = 4,
  parameter int RD_LOW     = 4,
  parameter int TIMEOUT    = 200
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    i_en,
  input  logic    i_eoc_n,
  input  sample_t i_db,
  output logic    o_convst_n,
  output logic    o_cs_n,
  output logic    o_rd_n,
  output logic    o_shdn,
  output sample_t o_sample_data,
  output logic    o_sample_valid,
  input  logic    i_sample_ready,
  output logic    o_overrun,
  output logic    o_timeout_err
);

  localparam int PW = $clog2(PERIOD);
  localparam int CW = $clog2(max3(CONVST_LOW, RD_LOW, TIMEOUT) + 1);

  localparam logic [PW-1:0] C_PERIOD_LOAD = PW'(PERIOD - 1);
  localparam logic [CW-1:0] C_CONV_LAST   = CW'(CONVST_LOW - 1);
  localparam logic [CW-1:0] C_RD_LAST     = CW'(RD_LOW - 1);
  localparam logic [CW-1:0] C_TO_LAST     = CW'(TIMEOUT - 1);

  adc_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_period;
  logic          r_convst_n;
  logic          r_cs_n;
  logic          r_rd_n;
  logic          r_timeout;
  sample_t       r_data;
  logic          r_valid;
  logic          r_overrun;

  logic          w_eoc_fall;
  logic          w_cap;

  sync_fall u_sync_fall (
    .clk       (clk),
    .rst       (rst),
    .i_async_n (i_eoc_n),
    .o_fall    (w_eoc_fall)
  );

  // Last READ cycle: DB is sampled at the end of this cycle.
  assign w_cap = (r_state == S_READ) && (r_cnt == C_RD_LAST);

  // Conversion sequencer; strobes are registered and change with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_period   <= '0;
      r_convst_n <= 1'b1;
      r_cs_n     <= 1'b1;
      r_rd_n     <= 1'b1;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      // Period counter free-runs down outside IDLE; a CONV entry below reloads it.
      if ((r_state != S_IDLE) && (r_period != '0)) begin
        r_period <= r_period - PW'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (i_en) begin
            r_state    <= S_CONV;
            r_cnt      <= '0;
            r_convst_n <= 1'b0;
            r_period   <= C_PERIOD_LOAD;
          end
        end
        S_CONV: begin
          if (r_cnt == C_CONV_LAST) begin
            r_state    <= S_WAIT_EOC;
            r_cnt      <= '0;
            r_convst_n <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_WAIT_EOC: begin
          if (w_eoc_fall) begin
            r_state <= S_READ;
            r_cnt   <= '0;
            r_cs_n  <= 1'b0;
            r_rd_n  <= 1'b0;
          end else if (r_cnt == C_TO_LAST) begin
            r_state   <= S_GAP;
            r_cnt     <= '0;
            r_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_READ: begin
          if (r_cnt == C_RD_LAST) begin
            r_state <= S_GAP;
            r_cnt   <= '0;
            r_cs_n  <= 1'b1;
            r_rd_n  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_GAP: begin
          if (r_period == '0) begin
            if (i_en) begin
              r_state    <= S_CONV;
              r_cnt      <= '0;
              r_convst_n <= 1'b0;
              r_period   <= C_PERIOD_LOAD;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Output sample register: load when empty or being consumed, else drop and flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_cap) begin
        if (!r_valid || i_sample_ready) begin
          r_data  <= i_db;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && i_sample_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_convst_n     = r_convst_n;
  assign o_cs_n         = r_cs_n;
  assign o_rd_n         = r_rd_n;
  assign o_shdn         = (r_state == S_IDLE) && !i_en;
  assign o_sample_data  = r_data;
  assign o_sample_valid = r_valid;
  assign o_overrun      = r_overrun;
  assign o_timeout_err  = r_timeout;

endmodule : adc_sampler
`default_nettype wire

// File: tb/tb_adc_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_sampler
//  Description : Directed self-checking bench for adc_sampler with a simple
//                ADC model and a sample scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_sampler;

  localparam int PERIOD = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        eoc_n;
  logic [15:0] db;
  logic        ready;
  logic        convst_n, cs_n, rd_n, shdn, valid, overrun, timeout_err;
  logic [15:0] data;

  int checks = 0;
  int errors = 0;

  // ADC model controls and scoreboard
  logic        adc_respond = 1'b0;
  logic        sb_skip     = 1'b0;
  logic [15:0] adc_value   = 16'h0;
  logic [15:0] sb[$];

  // Monitors
  int cyc = 0;
  int nfalls = 0;
  int falls[$];
  int hs_count = 0;
  int tcount = 0;
  int ocount = 0;
  int valid_seen = 0;
  logic prev_convst = 1'b1;

  int hs0, nf0, budget;

  adc_sampler #(
    .PERIOD     (PERIOD),
    .CONVST_LOW (4),
    .RD_LOW     (4),
    .TIMEOUT    (20)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_en           (en),
    .i_eoc_n        (eoc_n),
    .i_db           (db),
    .o_convst_n     (convst_n),
    .o_cs_n         (cs_n),
    .o_rd_n         (rd_n),
    .o_shdn         (shdn),
    .o_sample_data  (data),
    .o_sample_valid (valid),
    .i_sample_ready (ready),
    .o_overrun      (overrun),
    .o_timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_falls(input int n);
    int target;
    int b;
    target = nfalls + n;
    b = 0;
    while (nfalls < target && b < 200) begin
      tick();
      b++;
    end
    check("convst_start_wait", 32'(nfalls >= target), 32'd1);
  endtask

  task automatic wait_rd_low();
    int b;
    b = 0;
    while (rd_n && b < 100) begin
      tick();
      b++;
    end
    check("rd_low_wait", 32'(rd_n), 32'd0);
  endtask

  always @(posedge clk) cyc++;

  // Observe strobes and pulses away from the active edge
  always @(negedge clk) begin
    if (prev_convst && !convst_n) begin
      nfalls++;
      falls.push_back(cyc);
    end
    prev_convst = convst_n;
    if (timeout_err) tcount++;
    if (overrun) ocount++;
    if (valid) valid_seen++;
    if (!rst && valid && ready) begin
      hs_count++;
      if (sb.size() == 0) begin
        check("sb_unexpected_sample", 32'(data), 32'hFFFF_FFFF);
      end else begin
        check("sample_data", 32'(data), 32'(sb.pop_front()));
      end
    end
  end

  // ADC model: EOC low 10 cycles after CONVST rises, DB presented with it
  initial begin
    eoc_n = 1'b1;
    db    = 16'h0;
    forever begin
      @(posedge convst_n);
      if (adc_respond) begin
        repeat (10) @(posedge clk);
        #1;
        db = adc_value;
        if (!sb_skip) sb.push_back(adc_value);
        eoc_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        eoc_n = 1'b1;
      end
    end
  end

  initial begin
    rst   = 1'b1;
    en    = 1'b0;
    ready = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_convst", 32'(convst_n), 32'd1);
    check("rst_cs", 32'(cs_n), 32'd1);
    check("rst_rd", 32'(rd_n), 32'd1);
    check("rst_shdn", 32'(shdn), 32'd1);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);

    rst = 1'b0;
    tick();
    adc_respond = 1'b1;

    // Normal periodic conversions of 0x1234
    adc_value = 16'h1234;
    ready     = 1'b1;
    en        = 1'b1;
    hs_count  = 0;
    tick();
    check("shdn_running", 32'(shdn), 32'd0);
    wait_falls(1);
    wait_falls(1);
    wait_falls(1);
    check("period_a1", 32'(falls[$] - falls[$-1]), PERIOD);
    check("period_a2", 32'(falls[$-1] - falls[$-2]), PERIOD);
    check("samples_a", 32'(hs_count), 32'd2);

    // EOC never arrives: one timeout per period, no samples
    adc_respond = 1'b0;
    tcount      = 0;
    valid_seen  = 0;
    hs0         = hs_count;
    wait_falls(1);
    wait_falls(1);
    check("timeout_pulses", 32'(tcount), 32'd2);
    check("timeout_no_valid", 32'(valid_seen), 32'd0);
    check("timeout_no_hs", 32'(hs_count), 32'(hs0));
    check("period_b1", 32'(falls[$] - falls[$-1]), PERIOD);
    check("period_b2", 32'(falls[$-1] - falls[$-2]), PERIOD);

    // Overrun: ready low across captures of 0x0001 and 0x0002
    adc_respond = 1'b1;
    ready       = 1'b0;
    adc_value   = 16'h0001;
    ocount      = 0;
    wait_falls(1);
    adc_value = 16'h0002;
    sb_skip   = 1'b1;
    wait_falls(1);
    check("overrun_count", 32'(ocount), 32'd1);
    check("overrun_data_held", 32'(data), 32'h0001);
    check("overrun_valid", 32'(valid), 32'd1);
    sb_skip   = 1'b0;
    adc_value = 16'h0011;
    ready     = 1'b1;
    tick();
    ready = 1'b0;
    tick();
    check("consumed_valid_clear", 32'(valid), 32'd0);

    // Handshake on the capture cycle: 0x0011 consumed, 0x0022 loaded, no overrun
    wait_falls(1);
    adc_value = 16'h0022;
    ocount    = 0;
    wait_rd_low();
    repeat (3) @(posedge clk);
    #1 ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
    tick();
    tick();
    check("same_cycle_valid", 32'(valid), 32'd1);
    check("same_cycle_data", 32'(data), 32'h0022);
    check("same_cycle_no_overrun", 32'(ocount), 32'd0);
    check("same_cycle_pending", 32'(sb.size()), 32'd1);

    // en dropped during WAIT_EOC: sample still delivered, then idle
    ready = 1'b1;
    tick();
    wait_falls(1);
    adc_value = 16'h0033;
    hs0 = hs_count;
    repeat (8) tick();
    en  = 1'b0;
    nf0 = nfalls;
    repeat (80) tick();
    check("en_drop_delivered", 32'(hs_count), 32'(hs0 + 1));
    check("en_drop_no_convst", 32'(nfalls), 32'(nf0));
    check("en_drop_shdn", 32'(shdn), 32'd1);
    check("en_drop_convst_high", 32'(convst_n), 32'd1);
    check("en_drop_sb_empty", 32'(sb.size()), 32'd0);

    // Reset during READ: strobes forced high immediately, sample discarded
    ready     = 1'b0;
    adc_value = 16'h0044;
    en        = 1'b1;
    wait_rd_low();
    #2 rst = 1'b1;
    #1;
    check("rst_read_cs", 32'(cs_n), 32'd1);
    check("rst_read_rd", 32'(rd_n), 32'd1);
    check("rst_read_valid", 32'(valid), 32'd0);
    check("rst_read_sb", 32'(sb.size()), 32'd1);
    sb.delete();
    adc_value = 16'h0055;
    ready     = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    hs0 = hs_count;
    nf0 = nfalls;
    budget = 0;
    while (hs_count == hs0 && budget < 100) begin
      tick();
      budget++;
    end
    check("restart_sample", 32'(hs_count), 32'(hs0 + 1));
    check("restart_convst", 32'(nfalls), 32'(nf0 + 1));
    en = 1'b0;
    repeat (60) tick();
    check("final_sb_empty", 32'(sb.size()), 32'd0);
    check("final_shdn", 32'(shdn), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_adc_sampler
`default_nettype wire
